mem_port_arbiter: RTL and testbench

//  Shares the single-port 512x32 synchronous RAM between the CPU instruction-fetch

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch (I) and data (D) ports, with a fixed 4-state access sequence.
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              state_q;
  logic                last_d_q;   // 1 when the most recent grant went to D
  logic                gnt_d_q;    // port owning the access in flight
  logic                store_q;
  logic                ram_write_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_d_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                gnt_d_d;

  // D wins when it is the only requester, or on contention when I went last.
  always_comb begin
    gnt_d_d = d_req && (!i_req || !last_d_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b1;
      gnt_d_q     <= 1'b0;
      store_q     <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_d_q     <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req || d_req) begin
            gnt_d_q     <= gnt_d_d;
            last_d_q    <= gnt_d_d;
            store_q     <= gnt_d_d && d_we;
            ram_write_q <= gnt_d_d && d_we;
            ram_addr_q  <= gnt_d_d ? d_addr : i_addr;
            ram_d_q     <= gnt_d_d ? d_wdata : '0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_write_q <= 1'b0;
          state_q     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // RAM output reflects the address presented during ISSUE.
          if (!gnt_d_q) begin
            i_rdata_q <= ram_q;
            i_ack_q   <= 1'b1;
          end else begin
            if (!store_q) d_rdata_q <= ram_q;
            d_ack_q <= 1'b1;
          end
          state_q <= S_RESP;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_d     = ram_d_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural RAM, expected-ack scoreboard,
// and scenario tasks for arbitration, latency, fairness and mid-access reset.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic [DATA_W-1:0] ram_q;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] last_d = '0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  logic wr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;     // 0 = I, 1 = D
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t sb[$];

  // Background invariants: acks exclusive, write strobe is a single-cycle pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_ack || d_ack) begin
        vectors++;
        if (i_ack && d_ack) begin
          miscompares++;
          $display("FAIL ack_exclusive: got i_ack=%b d_ack=%b, want only one", i_ack, d_ack);
        end
      end
      if (ram_write) begin
        wr_cnt++;
        vectors++;
        if (wr_prev) begin
          miscompares++;
          $display("FAIL write_pulse: got ram_write high 2 cycles in a row at cyc %0d, want 1", cyc);
        end
      end
    end
    wr_prev = ram_write;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic i_fetch(input logic [ADDR_W-1:0] a, input int lat);
    exp_t e;
    i_addr = a;
    i_req  = 1'b1;
    e.port = 1'b0; e.data = ref_mem[a]; e.ack_cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic d_access(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input int lat);
    exp_t e;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    if (we) ref_mem[a] = wd;
    else    last_d = ref_mem[a];
    e.port = 1'b1; e.data = last_d; e.ack_cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // Pop one expectation per observed ack; a requester stays asserted while it
  // still has queued accesses and drops on the edge ending its final ack.
  task automatic drain(input int budget);
    int n;
    int left;
    exp_t e;
    bit got_d;
    logic [31:0] got;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (i_ack || d_ack) begin
        e = sb.pop_front();
        got_d = d_ack;
        got = got_d ? d_rdata : i_rdata;
        vectors++;
        if (got_d !== e.port) begin
          miscompares++;
          $display("FAIL ack_port: got port %0s, want %0s at cyc %0d",
                   got_d ? "D" : "I", e.port ? "D" : "I", cyc);
        end
        vectors++;
        if (got !== e.data) begin
          miscompares++;
          $display("FAIL rdata: got %h, want %h (port %0s)", got, e.data, e.port ? "D" : "I");
        end
        vectors++;
        if (cyc !== e.ack_cyc) begin
          miscompares++;
          $display("FAIL ack_latency: got ack at cyc %0d, want %0d", cyc, e.ack_cyc);
        end
        $display("ack port=%0s data=%h cyc=%0d", got_d ? "D" : "I", got, cyc);
        left = 0;
        foreach (sb[k]) if (sb[k].port == e.port) left++;
        if (left == 0) begin
          if (e.port) d_req = 1'b0;
          else        i_req = 1'b0;
        end
      end
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got %0d acks outstanding after %0d cycles, want 0", sb.size(), budget);
      sb.delete();
      i_req = 1'b0;
      d_req = 1'b0;
    end
  endtask

  task automatic watch_no_ack(input string name, input int ncyc);
    int seen;
    seen = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d ack cycles, want 0", name, seen);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, i_ack, d_ack, ram_write} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/i_ack/d_ack/ram_write=%b, want 0000",
               {busy, i_ack, d_ack, ram_write});
    end
    vectors++;
    if (ram_addr !== '0 || ram_d !== '0) begin
      miscompares++;
      $display("FAIL reset_ram_bus: got addr=%h d=%h, want 0/0", ram_addr, ram_d);
    end
    vectors++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got i=%h d=%h, want 0/0", i_rdata, d_rdata);
    end
    $display("reset check done busy=%b", busy);
  endtask

  task automatic test_store_load;
    @(posedge clk); #1;
    d_access(1'b1, 9'd300, 32'h1EC5_0000, 3);
    drain(20);
    @(posedge clk); #1;
    d_access(1'b0, 9'd300, 32'h0, 3);
    drain(20);
  endtask

  task automatic test_contention;
    @(posedge clk); #1;
    i_fetch(9'd0, 3);
    d_access(1'b0, 9'd104, 32'h0, 7);
    drain(30);
  endtask

  task automatic test_fairness;
    exp_t e;
    @(posedge clk); #1;
    i_addr = 9'd5; i_req = 1'b1;
    d_addr = 9'd9; d_we = 1'b0; d_wdata = '0; d_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      e.port    = j[0];
      e.data    = j[0] ? ref_mem[9] : ref_mem[5];
      e.ack_cyc = cyc + 3 + 4 * j;
      sb.push_back(e);
    end
    last_d = ref_mem[9];
    drain(60);
  endtask

  task automatic test_reset_in_capture;
    @(posedge clk); #1;
    i_addr = 9'd7; i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_d = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || i_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_reset_ctrl: got busy=%b i_ack=%b, want 0/0", busy, i_ack);
    end
    vectors++;
    if (i_rdata !== '0) begin
      miscompares++;
      $display("FAIL capture_reset_rdata: got %h, want 0", i_rdata);
    end
    watch_no_ack("capture_reset_noack", 6);
    @(posedge clk); #1;
    i_fetch(9'd7, 3);
    drain(20);
  endtask

  task automatic test_reset_after_issue;
    @(posedge clk); #1;
    d_we = 1'b1; d_addr = 9'd303; d_wdata = 32'hA780_0000; d_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    ref_mem[303] = 32'hA780_0000;
    last_d = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ram_write !== 1'b0) begin
      miscompares++;
      $display("FAIL issue_reset_ctrl: got busy=%b ram_write=%b, want 0/0", busy, ram_write);
    end
    watch_no_ack("issue_reset_noack", 6);
    @(posedge clk); #1;
    d_access(1'b0, 9'd303, 32'h0, 3);
    drain(20);
  endtask

  task automatic test_back_to_back;
    int w0;
    w0 = wr_cnt;
    @(posedge clk); #1;
    d_access(1'b1, 9'd77, 32'h5A5A_1234, 3);
    d_access(1'b1, 9'd77, 32'h5A5A_1234, 7);
    drain(30);
    vectors++;
    if (wr_cnt - w0 !== 2) begin
      miscompares++;
      $display("FAIL store_write_count: got %0d write cycles, want 2", wr_cnt - w0);
    end
    @(posedge clk); #1;
    d_access(1'b0, 9'd77, 32'h0, 3);
    drain(20);
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      mem[a]     = 32'h1000_0000 + a * 32'h0001_0101;
      ref_mem[a] = 32'h1000_0000 + a * 32'h0001_0101;
    end
    test_reset();
    test_store_load();
    test_contention();
    test_fairness();
    test_reset_in_capture();
    test_reset_after_issue();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
